// File: rtl/gcm_cipher_packer.sv
// gcm_cipher_packer: pairs 128-bit cipher blocks into 256-bit words with sideband.
// The words are buffered in a first-word-fall-through FIFO and leave through a valid/ready handshake.
module gcm_cipher_packer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic                       i_sop,
    input  logic                       i_eop,
    input  logic [127:0]               i_data,
    input  logic [4:0]                 i_bytes,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [255:0]               o_data,
    output logic                       o_sop,
    output logic                       o_eop,
    output logic [5:0]                 o_bytes,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic                       o_proto_err,
    output logic [CNT_W-1:0]           o_drop_count,
    output logic [CNT_W-1:0]           o_pkt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HALF = 1'b1;

    logic [0:0]   state;
    logic [127:0] held;
    logic         held_sop;
    logic [4:0]   eb;
    logic         restart, emit, pair, full, pop, push_ok, drop;
    logic [263:0] w_entry, head;
    logic [263:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // A beat restarts assembly when nothing is held or a new packet interrupts the held half
    always_comb begin
        eb      = (i_eop && i_bytes != 5'd0 && i_bytes <= 5'd16) ? i_bytes : 5'd16;
        restart = (state == IDLE) || i_sop;
        pair    = !restart;
        emit    = i_valid && (pair || i_eop);
        w_entry = pair ? {held_sop, i_eop, 6'd16 + {1'b0, eb}, held, i_data}
                       : {i_sop, 1'b1, {1'b0, eb}, i_data, 128'd0};
        full    = o_level == LW'(DEPTH);
        pop     = o_valid && o_ready;
        push_ok = emit && (!full || pop);
        drop    = emit && full && !pop;
        head    = mem[rd_ptr];
    end

    assign o_valid = o_level != '0;
    assign o_sop   = head[263];
    assign o_eop   = head[262];
    assign o_bytes = head[261:256];
    assign o_data  = head[255:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            held        <= '0;
            held_sop    <= 1'b0;
            o_proto_err <= 1'b0;
        end else if (i_valid) begin
            if (state == HALF && i_sop)
                o_proto_err <= 1'b1;
            if (restart && !i_eop) begin
                state    <= HALF;
                held     <= i_data;
                held_sop <= i_sop;
            end else begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_level      <= '0;
            o_overflow   <= 1'b0;
            o_drop_count <= '0;
            o_pkt_count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                o_level <= o_level + 1'b1;
            else if (pop && !push_ok)
                o_level <= o_level - 1'b1;
            if (drop) begin
                o_overflow <= 1'b1;
                if (o_drop_count != '1)
                    o_drop_count <= o_drop_count + 1'b1;
            end
            if (pop && o_eop)
                o_pkt_count <= o_pkt_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_gcm_cipher_packer.sv
// tb_gcm_cipher_packer: directed vectors with a scoreboard queue checked by an output monitor.
module tb_gcm_cipher_packer;
    logic         clk = 1'b0;
    logic         reset, i_valid, i_sop, i_eop, o_valid, o_ready, o_sop, o_eop;
    logic         o_overflow, o_proto_err;
    logic [127:0] i_data;
    logic [4:0]   i_bytes;
    logic [255:0] o_data;
    logic [5:0]   o_bytes;
    logic [3:0]   o_level;
    logic [15:0]  o_drop_count, o_pkt_count;
    logic [263:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    gcm_cipher_packer #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop),
        .i_data(i_data), .i_bytes(i_bytes), .o_valid(o_valid), .o_ready(o_ready),
        .o_data(o_data), .o_sop(o_sop), .o_eop(o_eop), .o_bytes(o_bytes),
        .o_level(o_level), .o_overflow(o_overflow), .o_proto_err(o_proto_err),
        .o_drop_count(o_drop_count), .o_pkt_count(o_pkt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] blk(input logic [15:0] n);
        return {8{n}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic s, input logic e, input logic [127:0] d, input logic [4:0] b);
        i_valid = 1'b1;
        i_sop   = s;
        i_eop   = e;
        i_data  = d;
        i_bytes = b;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || o_valid) && k < 200) begin
            tick();
            k++;
        end
        chk("drain_timeout", 64'(k < 200), 64'd1);
    endtask

    // Pops occur at the following posedge; inputs only change 1ns after posedge
    always @(negedge clk) begin
        if (!reset && o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %0h, expected none", {o_sop, o_eop, o_bytes, o_data});
            end else begin
                logic [263:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if ({o_sop, o_eop, o_bytes, o_data} !== e) begin
                    n_bad++;
                    $display("FAIL word: got %0h, expected %0h", {o_sop, o_eop, o_bytes, o_data}, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        i_data = '0; i_bytes = '0; o_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_flags", 64'({o_overflow, o_proto_err}), 64'd0);
        chk("rst_counts", 64'({o_drop_count, o_pkt_count}), 64'd0);

        o_ready = 1'b1;
        beat(1, 0, blk(16'hA000), 0);
        chk("no_early_valid", 64'(o_valid), 64'd0);
        exp_q.push_back({1'b1, 1'b1, 6'd32, blk(16'hA000), blk(16'hB000)});
        beat(0, 1, blk(16'hB000), 16);
        chk("latency_valid", 64'(o_valid), 64'd1);
        drain();
        chk("pkt_count_1", 64'(o_pkt_count), 64'd1);

        exp_q.push_back({1'b1, 1'b0, 6'd32, blk(16'hA001), blk(16'hB001)});
        exp_q.push_back({1'b0, 1'b1, 6'd5, blk(16'hC001), 128'd0});
        exp_q.push_back({1'b1, 1'b1, 6'd16, blk(16'hD001), 128'd0});
        beat(1, 0, blk(16'hA001), 0);
        beat(0, 0, blk(16'hB001), 0);
        beat(0, 1, blk(16'hC001), 5);
        beat(1, 1, blk(16'hD001), 0);
        drain();
        chk("pkt_count_3", 64'(o_pkt_count), 64'd3);

        o_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8)
                exp_q.push_back({1'b1, 1'b1, 6'(i + 1), blk(16'h0100 + 16'(i)), 128'd0});
            beat(1, 1, blk(16'h0100 + 16'(i)), 5'(i + 1));
        end
        chk("full_level", 64'(o_level), 64'd8);
        chk("overflow", 64'(o_overflow), 64'd1);
        chk("drop_count_1", 64'(o_drop_count), 64'd1);
        o_ready = 1'b1;
        exp_q.push_back({1'b1, 1'b1, 6'd16, blk(16'h0200), 128'd0});
        beat(1, 1, blk(16'h0200), 20);
        chk("full_pushpop_level", 64'(o_level), 64'd8);
        chk("full_pushpop_drop", 64'(o_drop_count), 64'd1);
        drain();
        chk("pkt_count_12", 64'(o_pkt_count), 64'd12);

        beat(1, 0, blk(16'hA002), 0);
        exp_q.push_back({1'b1, 1'b1, 6'd16, blk(16'hD002), 128'd0});
        beat(1, 1, blk(16'hD002), 16);
        chk("proto_err", 64'(o_proto_err), 64'd1);
        drain();
        chk("overflow_sticky", 64'(o_overflow), 64'd1);
        chk("pkt_count_13", 64'(o_pkt_count), 64'd13);

        o_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            beat(1, 1, blk(16'h0300 + 16'(i)), 4);
        beat(1, 0, blk(16'hA003), 0);
        chk("pre_rst_level", 64'(o_level), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_level", 64'(o_level), 64'd0);
        chk("mid_rst_counts", 64'({o_drop_count, o_pkt_count}), 64'd0);
        chk("mid_rst_flags", 64'({o_overflow, o_proto_err}), 64'd0);
        o_ready = 1'b1;
        exp_q.push_back({1'b1, 1'b1, 6'd23, blk(16'hA004), blk(16'hB004)});
        beat(1, 0, blk(16'hA004), 0);
        beat(0, 1, blk(16'hB004), 7);
        drain();
        chk("post_rst_pkt", 64'(o_pkt_count), 64'd1);
        chk("post_rst_err", 64'(o_proto_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
